// File: rtl/coeffr_serial_loader_pkg.sv
// Shared constants and state encoding for the right-channel coefficient loader.
package coeffr_serial_loader_pkg;

  localparam int N_COEFF_DEF = 512;
  localparam int WORD_W_DEF  = 16;
  localparam int ROW_W_DEF   = 9;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_FRAME,
    SHIFT,
    STAGE,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/coeffr_serial_loader_serial_shift16.sv
// MSB-first serial deserialiser with bit counter, word-complete flag and
// mid-word Frame detection; reusable for any framed serial word stream.
module serial_shift16
  import coeffr_serial_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              run,
  input  logic              bit_en,
  input  logic              frame,
  input  logic              din,
  output logic [WORD_W-1:0] word,
  output logic              word_complete,
  output logic              frame_restart
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0] bitcnt;

  // A Frame mid-word restarts the word with this bit as its new MSB.
  assign frame_restart = run & bit_en & frame & (bitcnt != '0);
  assign word_complete = run & bit_en & ~frame_restart & (bitcnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      word   <= '0;
      bitcnt <= '0;
    end else if (arm && bit_en && frame) begin
      word   <= {{(WORD_W-1){1'b0}}, din};
      bitcnt <= CNT_W'(1);
    end else if (run && bit_en) begin
      word <= {word[WORD_W-2:0], din};
      if (frame_restart)
        bitcnt <= CNT_W'(1);
      else if (word_complete)
        bitcnt <= '0;
      else
        bitcnt <= bitcnt + 1'b1;
    end
  end

endmodule

// File: rtl/coeffr_serial_loader.sv
// Right-channel coefficient loader: clears the coefficient memory, then writes
// N_COEFF deserialised words to consecutive rows and flags completion.
//
//   state      | meaning
//   IDLE       | waiting for Start
//   CLEAR      | clear pulse high, row and frame_err zeroed
//   WAIT_FRAME | discard bits until Frame marks a word MSB
//   SHIFT      | collecting bits of the current word
//   STAGE      | present the finished word on coeff_word
//   WRITE      | word and row settled; write strobe issued on exit
//   DONE       | all rows written, load_done high
module coeffr_serial_loader
  import coeffr_serial_loader_pkg::*;
#(
  parameter int N_COEFF = N_COEFF_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int ROW_W   = ROW_W_DEF
) (
  input  logic              Sclk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              bit_en,
  input  logic              Frame,
  input  logic              InputR,
  output logic              clear,
  output logic              coeff_status,
  output logic [ROW_W-1:0]  row,
  output logic [WORD_W-1:0] coeff_word,
  output logic              load_done,
  output logic              frame_err
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_COEFF - 1);

  state_t            state;
  logic [WORD_W-1:0] shift_word;
  logic              word_complete;
  logic              frame_restart;
  logic              arm;
  logic              run;

  assign arm = (state == WAIT_FRAME);
  assign run = (state == SHIFT);

  serial_shift16 #(
    .WORD_W(WORD_W)
  ) u_shift (
    .clk          (Sclk),
    .rst          (Reset),
    .arm          (arm),
    .run          (run),
    .bit_en       (bit_en),
    .frame        (Frame),
    .din          (InputR),
    .word         (shift_word),
    .word_complete(word_complete),
    .frame_restart(frame_restart)
  );

  always_ff @(posedge Sclk) begin
    if (Reset) begin
      state        <= IDLE;
      clear        <= 1'b0;
      coeff_status <= 1'b0;
      row          <= '0;
      coeff_word   <= '0;
      load_done    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      clear        <= 1'b0;
      coeff_status <= 1'b0;
      // Row advances the cycle after the strobe so it is stable while the memory writes.
      if (coeff_status && (row != LAST_ROW))
        row <= row + 1'b1;
      if (frame_restart)
        frame_err <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state     <= CLEAR;
            clear     <= 1'b1;
            row       <= '0;
            frame_err <= 1'b0;
            load_done <= 1'b0;
          end
        end
        CLEAR: begin
          row       <= '0;
          frame_err <= 1'b0;
          state     <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (bit_en && Frame)
            state <= SHIFT;
        end
        SHIFT: begin
          if (word_complete)
            state <= STAGE;
        end
        STAGE: begin
          coeff_word <= shift_word;
          state      <= WRITE;
        end
        WRITE: begin
          coeff_status <= 1'b1;
          if (row == LAST_ROW) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else begin
            state <= WAIT_FRAME;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coeffr_serial_loader.sv
// Directed/random bench for coeffr_serial_loader with a strobe monitor and
// per-load expected-word tables.
module tb_coeffr_serial_loader;

  localparam int N = 512;

  logic        Sclk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        bit_en = 1'b0;
  logic        Frame = 1'b0;
  logic        InputR = 1'b0;
  logic        clear;
  logic        coeff_status;
  logic [8:0]  row;
  logic [15:0] coeff_word;
  logic        load_done;
  logic        frame_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Sclk = ~Sclk;

  coeffr_serial_loader dut (
    .Sclk        (Sclk),
    .Reset       (Reset),
    .Start       (Start),
    .bit_en      (bit_en),
    .Frame       (Frame),
    .InputR      (InputR),
    .clear       (clear),
    .coeff_status(coeff_status),
    .row         (row),
    .coeff_word  (coeff_word),
    .load_done   (load_done),
    .frame_err   (frame_err)
  );

  int unsigned cyc = 0;
  always @(posedge Sclk) cyc <= cyc + 1;

  // Strobe monitor: records what the memory would see on each write.
  logic        prev_status = 1'b0;
  logic [15:0] prev_word = '0;
  logic [15:0] prev2_word = '0;
  logic [8:0]  prev_row = '0;
  int          clear_cnt = 0;
  int          dbl_cnt = 0;
  logic [8:0]  m_row[$];
  logic [15:0] m_word[$];
  logic [15:0] m_pre[$];
  logic [15:0] m_pre2[$];
  logic [8:0]  m_pre_row[$];
  logic [8:0]  m_after[$];
  int unsigned m_cyc[$];

  always @(negedge Sclk) begin
    if (clear) clear_cnt++;
    if (coeff_status) begin
      m_row.push_back(row);
      m_word.push_back(coeff_word);
      m_pre.push_back(prev_word);
      m_pre2.push_back(prev2_word);
      m_pre_row.push_back(prev_row);
      m_cyc.push_back(cyc);
      if (prev_status) dbl_cnt++;
    end
    if (prev_status && !coeff_status) m_after.push_back(row);
    prev2_word  = prev_word;
    prev_word   = coeff_word;
    prev_status = coeff_status;
    prev_row    = row;
  end

  int unsigned last_bit_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after a falling edge; leaves bits 4 cycles apart.
  task automatic send_bit(input logic f, input logic b);
    bit_en = 1'b1; Frame = f; InputR = b;
    last_bit_cyc = cyc;
    @(negedge Sclk);
    bit_en = 1'b0; Frame = 1'b0; InputR = 1'b0;
    repeat (3) @(negedge Sclk);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(i == 15, w[i]);
  endtask

  task automatic check_load(input string name, input int base, input int cnt,
                            input int last_row, input logic [15:0] exp_w[N]);
    for (int k = 0; k < cnt; k++) begin
      chk($sformatf("%s_row%0d", name, k), m_row[base+k], k);
      chk($sformatf("%s_word%0d", name, k), m_word[base+k], exp_w[k]);
      chk($sformatf("%s_prerow%0d", name, k), m_pre_row[base+k], k);
      chk($sformatf("%s_preword%0d", name, k), m_pre[base+k], exp_w[k]);
      chk($sformatf("%s_after%0d", name, k), m_after[base+k], (k < last_row) ? k + 1 : k);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] exp1[N];
  logic [15:0] exp2[N];
  logic [15:0] exp3[N];
  int          base;
  int unsigned c_ffff;

  initial begin
    for (int k = 0; k < N; k++) begin
      exp1[k] = 16'(k) ^ 16'h5A5A;
      exp2[k] = 16'($urandom);
      exp3[k] = 16'($urandom);
    end
    exp1[0] = 16'hA5C3;
    exp1[1] = 16'h0001;
    exp1[3] = 16'h1234;
    exp1[4] = 16'hFFFF;

    // Reset state
    repeat (3) @(negedge Sclk);
    chk("rst_clear", clear, 0);
    chk("rst_status", coeff_status, 0);
    chk("rst_row", row, 0);
    chk("rst_word", coeff_word, 0);
    chk("rst_done", load_done, 0);
    chk("rst_ferr", frame_err, 0);
    Reset = 1'b0;
    @(negedge Sclk);

    // Start together with a framed bit in IDLE: Start wins, bit dropped
    Start = 1'b1; bit_en = 1'b1; Frame = 1'b1; InputR = 1'b1;
    @(negedge Sclk);
    Start = 1'b0; bit_en = 1'b0; Frame = 1'b0; InputR = 1'b0;
    chk("start_clear_hi", clear, 1);
    chk("start_row0", row, 0);
    @(negedge Sclk);
    chk("start_clear_lo", clear, 0);

    // Load 1: full 512-word load with a truncated word before row 3
    for (int k = 0; k < N; k++) begin
      if (k == 3) begin
        send_bit(1'b1, 1'($urandom));
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'($urandom));
      end
      if (k == 5) begin
        chk("row_before_midstart", row, 5);
        Start = 1'b1;
        @(negedge Sclk);
        Start = 1'b0;
        chk("midstart_no_clear", clear, 0);
      end
      send_word(exp1[k]);
      if (k == 1) chk("ferr_clean", frame_err, 0);
      if (k == 3) chk("ferr_set", frame_err, 1);
      if (k == 4) c_ffff = last_bit_cyc;
    end
    repeat (4) @(negedge Sclk);
    #2;
    chk("l1_done", load_done, 1);
    chk("l1_ferr", frame_err, 1);
    chk("l1_row", row, N - 1);
    chk("l1_strobes", m_row.size(), N);
    chk("l1_after_cnt", m_after.size(), N);
    chk("l1_clear_cnt", clear_cnt, 1);
    chk("l1_dbl", dbl_cnt, 0);
    if (m_row.size() >= N && m_after.size() >= N) check_load("l1", 0, N, N - 1, exp1);
    if (m_cyc.size() > 4) begin
      chk("ffff_latency", m_cyc[4] - c_ffff, 3);
      chk("ffff_pre", m_pre[4], 16'hFFFF);
      chk("ffff_pre2", m_pre2[4], 16'h1234);
    end

    // Bits in DONE are ignored; row never wraps
    @(negedge Sclk);
    send_word(16'($urandom));
    #2;
    chk("done_hold_strobes", m_row.size(), N);
    chk("done_hold_row", row, N - 1);
    chk("done_hold_word", coeff_word, exp1[N-1]);
    chk("done_hold_flag", load_done, 1);

    // Start in DONE
    @(negedge Sclk);
    Start = 1'b1;
    @(negedge Sclk);
    Start = 1'b0;
    chk("restart_clear_hi", clear, 1);
    chk("restart_ferr", frame_err, 0);
    chk("restart_row", row, 0);
    chk("restart_done", load_done, 0);
    @(negedge Sclk);
    chk("restart_clear_lo", clear, 0);

    // Load 2: random words, Reset lands in WRITE of row 10
    base = m_row.size();
    for (int k = 0; k < 10; k++) send_word(exp2[k]);
    for (int i = 15; i >= 1; i--) send_bit(i == 15, exp2[10][i]);
    bit_en = 1'b1; InputR = exp2[10][0];
    @(negedge Sclk);
    bit_en = 1'b0; InputR = 1'b0;
    @(negedge Sclk);
    chk("wr10_status_pre", coeff_status, 0);
    chk("wr10_word_staged", coeff_word, exp2[10]);
    chk("wr10_row", row, 10);
    Reset = 1'b1;
    @(negedge Sclk);
    Reset = 1'b0;
    chk("wr10_rst_status", coeff_status, 0);
    chk("wr10_rst_row", row, 0);
    chk("wr10_rst_word", coeff_word, 0);
    chk("wr10_rst_done", load_done, 0);
    repeat (4) @(negedge Sclk);
    #2;
    chk("l2_strobes", m_row.size() - base, 10);
    chk("l2_clear_cnt", clear_cnt, 2);
    chk("l2_idle_clear", clear, 0);
    if (m_row.size() >= base + 10 && m_after.size() >= base + 10)
      check_load("l2", base, 10, N - 1, exp2);

    // Load 3: fresh Start reloads from row 0
    @(negedge Sclk);
    Start = 1'b1;
    @(negedge Sclk);
    Start = 1'b0;
    chk("l3_clear_hi", clear, 1);
    chk("l3_row0", row, 0);
    @(negedge Sclk);
    base = m_row.size();
    for (int k = 0; k < 3; k++) send_word(exp3[k]);
    #2;
    chk("l3_strobes", m_row.size() - base, 3);
    chk("l3_clear_cnt", clear_cnt, 3);
    chk("l3_row_now", row, 3);
    chk("l3_ferr", frame_err, 0);
    chk("l3_dbl", dbl_cnt, 0);
    if (m_row.size() >= base + 3 && m_after.size() >= base + 3)
      check_load("l3", base, 3, N - 1, exp3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
